// File: rtl/operand_issue.sv
// Operand issue stage: reads two source registers, blocks on scoreboard hazards, issues to execute; also sequences regfile writebacks.
// Latency: operands valid two cycles after the accept cycle (one READ cycle); writeback strobes W on the second cycle after its accept.
// Backpressure: in_ready only in IDLE, outputs held while out_ready low; wb_ready only while the writeback sequencer is idle.
module operand_issue (
   input  logic        clk,
   input  logic        rst_n,
   // upstream decoded instruction
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic        in_wen,
   input  logic [3:0]  in_dst,
   input  logic [3:0]  in_src0,
   input  logic [3:0]  in_src1,
   // register-file read ports (data combinational from the selects)
   output logic [3:0]  rsel0,
   output logic [3:0]  rsel1,
   input  logic [15:0] dout0,
   input  logic [15:0] dout1,
   // downstream execute handshake and issued operands
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_op,
   output logic [3:0]  out_dst,
   output logic        out_wen,
   output logic [15:0] out_a,
   output logic [15:0] out_b,
   // writeback request from execute
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [3:0]  wb_dst,
   input  logic [15:0] wb_data,
   // register-file write port
   output logic [3:0]  wsel,
   output logic [15:0] din,
   output logic        w,
   // issue blocked by a scoreboard hazard
   output logic        stall
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } iss_state_t;

   typedef enum logic [1:0] {
      WB_IDLE   = 2'd0,
      WB_SETUP  = 2'd1,
      WB_STROBE = 2'd2
   } wb_state_t;

   iss_state_t iss_q, iss_d;
   wb_state_t  wb_q, wb_d;

   // latched instruction fields; the source indices live in rsel0/rsel1
   logic [3:0]  op_q;
   logic [3:0]  dst_q;
   logic        wen_q;

   // one pending-write bit per architectural register
   logic [15:0] pend_q;
   logic [15:0] pend_d;

   logic accept;
   logic hazard;
   logic issue_fire;
   logic hold_release;
   logic wb_accept;
   logic wb_done;

   // ---------------------------------------------------------------
   // Issue FSM
   // ---------------------------------------------------------------

   // issue state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_q <= IDLE;
      end else begin
         iss_q <= iss_d;
      end
   end

   // issue next-state, handshake and hazard decode; hazard uses the registered scoreboard only (no forwarding)
   always_comb begin
      iss_d        = iss_q;
      in_ready     = 1'b0;
      accept       = 1'b0;
      stall        = 1'b0;
      issue_fire   = 1'b0;
      hold_release = 1'b0;
      hazard       = pend_q[rsel0] | pend_q[rsel1] | (wen_q & pend_q[dst_q]);
      case (iss_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               iss_d  = READ;
            end
         end
         READ: begin
            if (hazard) begin
               stall = 1'b1;
            end else begin
               issue_fire = 1'b1;
               iss_d      = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               hold_release = 1'b1;
               iss_d        = IDLE;
            end
         end
         default: begin
            iss_d = IDLE;
         end
      endcase
   end

   // capture the accepted instruction and point the read ports at its sources
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= 4'd0;
         dst_q <= 4'd0;
         wen_q <= 1'b0;
         rsel0 <= 4'd0;
         rsel1 <= 4'd0;
      end else if (accept) begin
         op_q  <= in_op;
         dst_q <= in_dst;
         wen_q <= in_wen;
         rsel0 <= in_src0;
         rsel1 <= in_src1;
      end
   end

   // issued operand register: loads on issue, holds the last issued values otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_op    <= 4'd0;
         out_dst   <= 4'd0;
         out_wen   <= 1'b0;
         out_a     <= 16'd0;
         out_b     <= 16'd0;
      end else if (issue_fire) begin
         out_valid <= 1'b1;
         out_op    <= op_q;
         out_dst   <= dst_q;
         out_wen   <= wen_q;
         out_a     <= dout0;
         out_b     <= dout1;
      end else if (hold_release) begin
         out_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Writeback sequencer
   // ---------------------------------------------------------------

   // writeback state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q <= WB_IDLE;
      end else begin
         wb_q <= wb_d;
      end
   end

   // writeback next-state: setup cycle, strobe cycle, then back to idle
   always_comb begin
      wb_d      = wb_q;
      wb_ready  = 1'b0;
      wb_accept = 1'b0;
      wb_done   = 1'b0;
      case (wb_q)
         WB_IDLE: begin
            wb_ready = 1'b1;
            if (wb_valid) begin
               wb_accept = 1'b1;
               wb_d      = WB_SETUP;
            end
         end
         WB_SETUP: begin
            wb_d = WB_STROBE;
         end
         WB_STROBE: begin
            wb_done = 1'b1;
            wb_d    = WB_IDLE;
         end
         default: begin
            wb_d = WB_IDLE;
         end
      endcase
   end

   // write port: address/data held from setup until the next accepted request; W is a flop so it cannot glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wsel <= 4'd0;
         din  <= 16'd0;
         w    <= 1'b0;
      end else begin
         if (wb_accept) begin
            wsel <= wb_dst;
            din  <= wb_data;
         end
         w <= (wb_d == WB_STROBE);
      end
   end

   // ---------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------

   // clear on writeback completion, then set on issue so a same-edge set wins
   always_comb begin
      pend_d = pend_q;
      if (wb_done) begin
         pend_d[wsel] = 1'b0;
      end
      if (issue_fire && wen_q) begin
         pend_d[dst_q] = 1'b1;
      end
   end

   // scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 16'd0;
      end else begin
         pend_q <= pend_d;
      end
   end

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios plus randomized issue/writeback traffic.
// Reference keeps architectural register values and the set of registers with a write in flight.
// All DUT outputs are sampled 1 time unit after the rising clock edge.
module tb_operand_issue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic        in_wen;
   logic [3:0]  in_dst;
   logic [3:0]  in_src0;
   logic [3:0]  in_src1;
   logic [3:0]  rsel0;
   logic [3:0]  rsel1;
   logic [15:0] dout0;
   logic [15:0] dout1;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [3:0]  out_dst;
   logic        out_wen;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_dst;
   logic [15:0] wb_data;
   logic [3:0]  wsel;
   logic [15:0] din;
   logic        w;
   logic        stall;

   // register file attached to the DUT (environment, not reference)
   logic [15:0] rf [16];
   logic        ld;
   logic [3:0]  ld_idx;
   logic [15:0] ld_val;

   // reference model: architectural values and registers awaiting a write
   logic [15:0] shadow [16];
   bit   [15:0] mpend;

   int n_cmp = 0;
   int n_err = 0;

   operand_issue dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_wen    (in_wen),
      .in_dst    (in_dst),
      .in_src0   (in_src0),
      .in_src1   (in_src1),
      .rsel0     (rsel0),
      .rsel1     (rsel1),
      .dout0     (dout0),
      .dout1     (dout1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_dst   (out_dst),
      .out_wen   (out_wen),
      .out_a     (out_a),
      .out_b     (out_b),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_dst    (wb_dst),
      .wb_data   (wb_data),
      .wsel      (wsel),
      .din       (din),
      .w         (w),
      .stall     (stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign dout0 = rf[rsel0];
   assign dout1 = rf[rsel1];

   // register file: writes on the rising edge of W, preloads via ld
   initial begin
      forever begin
         @(posedge w or posedge ld);
         if (ld) rf[ld_idx] = ld_val;
         else    rf[wsel]   = din;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] r, input logic [15:0] v);
      ld_idx = r;
      ld_val = v;
      ld = 1'b1;
      #1;
      ld = 1'b0;
      #1;
      shadow[r] = v;
   endtask

   // one writeback request with its full timing checked; updates the model on completion
   task automatic do_wb(input logic [3:0] r, input logic [15:0] d);
      int n;
      n = 0;
      while (!wb_ready && n < 10) begin
         cyc();
         n++;
      end
      chk("wb_rdy", 32'(wb_ready), 1);
      wb_valid = 1'b1;
      wb_dst   = r;
      wb_data  = d;
      cyc();
      wb_valid = 1'b0;
      wb_dst   = 4'($urandom);
      wb_data  = 16'($urandom);
      chk("setup_w",    32'(w), 0);
      chk("setup_wsel", 32'(wsel), 32'(r));
      chk("setup_din",  32'(din), 32'(d));
      chk("setup_rdy",  32'(wb_ready), 0);
      cyc();
      chk("strobe_w",    32'(w), 1);
      chk("strobe_rdy",  32'(wb_ready), 0);
      chk("strobe_wsel", 32'(wsel), 32'(r));
      chk("strobe_din",  32'(din), 32'(d));
      cyc();
      chk("post_w",    32'(w), 0);
      chk("post_rdy",  32'(wb_ready), 1);
      chk("post_wsel", 32'(wsel), 32'(r));
      chk("post_din",  32'(din), 32'(d));
      chk("rf_wr",     32'(rf[r]), 32'(d));
      shadow[r] = d;
      mpend[r]  = 1'b0;
   endtask

   // issue one instruction; any blocking registers are written back with wbd
   task automatic issue(input logic [3:0] op, input logic wen, input logic [3:0] dst,
                        input logic [3:0] s0, input logic [3:0] s1,
                        input logic [15:0] wbd, input int hold, input int pre);
      bit   [15:0] blk;
      logic [15:0] ea;
      logic [15:0] eb;
      blk = '0;
      if (mpend[s0])         blk[s0]  = 1'b1;
      if (mpend[s1])         blk[s1]  = 1'b1;
      if (wen && mpend[dst]) blk[dst] = 1'b1;
      chk("idle_rdy", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_op    = op;
      in_wen   = wen;
      in_dst   = dst;
      in_src0  = s0;
      in_src1  = s1;
      cyc();
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_wen   = 1'($urandom);
      in_dst   = 4'($urandom);
      in_src0  = 4'($urandom);
      in_src1  = 4'($urandom);
      chk("acc_rdy",   32'(in_ready), 0);
      chk("rsel0",     32'(rsel0), 32'(s0));
      chk("rsel1",     32'(rsel1), 32'(s1));
      chk("stall",     32'(stall), 32'(blk != 0));
      chk("early_vld", 32'(out_valid), 0);
      if (blk != 0) begin
         for (int i = 0; i < pre; i++) begin
            cyc();
            chk("stall_hold", 32'(stall), 1);
            chk("stall_vld",  32'(out_valid), 0);
            chk("stall_rsel", 32'(rsel0), 32'(s0));
         end
         for (int r = 0; r < 16; r++) begin
            if (blk[r]) do_wb(4'(r), wbd);
         end
      end
      cyc();
      ea = shadow[s0];
      eb = shadow[s1];
      chk("vld",     32'(out_valid), 1);
      chk("out_a",   32'(out_a), 32'(ea));
      chk("out_b",   32'(out_b), 32'(eb));
      chk("out_op",  32'(out_op), 32'(op));
      chk("out_dst", 32'(out_dst), 32'(dst));
      chk("out_wen", 32'(out_wen), 32'(wen));
      if (wen) mpend[dst] = 1'b1;
      for (int i = 0; i < hold; i++) begin
         cyc();
         chk("hold_vld", 32'(out_valid), 1);
         chk("hold_a",   32'(out_a), 32'(ea));
         chk("hold_b",   32'(out_b), 32'(eb));
         chk("hold_rdy", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("rel_vld", 32'(out_valid), 0);
      chk("rel_rdy", 32'(in_ready), 1);
      chk("rel_a",   32'(out_a), 32'(ea));
      chk("rel_b",   32'(out_b), 32'(eb));
   endtask

   task automatic rand_phase(input int n);
      int r;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(9, 0) < 7) begin
            issue(4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  16'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
         end else begin
            r = int'($urandom_range(15, 0));
            if (mpend != 0 && $urandom_range(1, 0) == 1) begin
               while (!mpend[r]) r = (r + 1) % 16;
            end
            do_wb(4'(r), 16'($urandom));
         end
      end
   endtask

   initial begin
      logic [15:0] d;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 4'd0;
      in_wen    = 1'b0;
      in_dst    = 4'd0;
      in_src0   = 4'd0;
      in_src1   = 4'd0;
      out_ready = 1'b0;
      wb_valid  = 1'b0;
      wb_dst    = 4'd0;
      wb_data   = 16'd0;
      ld        = 1'b0;
      ld_idx    = 4'd0;
      ld_val    = 16'd0;
      mpend     = '0;
      #2;
      for (int r = 0; r < 16; r++) load(4'(r), 16'($urandom));
      load(4'd3, 16'h1234);
      load(4'd5, 16'h00FF);
      cyc();
      cyc();

      // reset state
      chk("rst_in_rdy",  32'(in_ready), 1);
      chk("rst_wb_rdy",  32'(wb_ready), 1);
      chk("rst_vld",     32'(out_valid), 0);
      chk("rst_w",       32'(w), 0);
      chk("rst_wsel",    32'(wsel), 0);
      chk("rst_din",     32'(din), 0);
      chk("rst_rsel0",   32'(rsel0), 0);
      chk("rst_rsel1",   32'(rsel1), 0);
      chk("rst_a",       32'(out_a), 0);
      chk("rst_b",       32'(out_b), 0);
      chk("rst_op",      32'(out_op), 0);
      chk("rst_dst",     32'(out_dst), 0);
      chk("rst_wen",     32'(out_wen), 0);
      chk("rst_stall",   32'(stall), 0);
      rst_n = 1'b1;

      // basic issue, accepted on the first edge after reset release
      issue(4'h2, 1'b0, 4'h0, 4'd3, 4'd5, 16'h0000, 0, 0);
      chk("basic_a", 32'(out_a), 32'h1234);
      chk("basic_b", 32'(out_b), 32'h00FF);

      // RAW hazard on R4 resolved by writeback of BEEF
      issue(4'h1, 1'b1, 4'd4, 4'd1, 4'd2, 16'h0000, 0, 0);
      issue(4'h3, 1'b0, 4'd0, 4'd4, 4'd6, 16'hBEEF, 0, 3);
      chk("raw_a", 32'(out_a), 32'hBEEF);

      // backpressure for five cycles
      issue(4'h5, 1'b0, 4'd0, 4'd3, 4'd5, 16'h0000, 5, 0);

      // writeback timing to R10
      do_wb(4'd10, 16'h5A5A);
      chk("wb_r10", 32'(rf[10]), 32'h5A5A);

      // R7 writeback completes on the same edge an instruction with DST=7 issues
      d = 16'($urandom);
      wb_valid = 1'b1;
      wb_dst   = 4'd7;
      wb_data  = d;
      cyc();
      wb_valid = 1'b0;
      in_valid = 1'b1;
      in_op    = 4'h9;
      in_wen   = 1'b1;
      in_dst   = 4'd7;
      in_src0  = 4'd0;
      in_src1  = 4'd1;
      cyc();
      in_valid = 1'b0;
      chk("col_w",     32'(w), 1);
      chk("col_stall", 32'(stall), 0);
      cyc();
      chk("col_vld",   32'(out_valid), 1);
      chk("col_w0",    32'(w), 0);
      chk("col_a",     32'(out_a), 32'(shadow[0]));
      chk("col_b",     32'(out_b), 32'(shadow[1]));
      chk("col_dst",   32'(out_dst), 7);
      chk("col_rf",    32'(rf[7]), 32'(d));
      shadow[7] = d;
      mpend[7]  = 1'b1;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      issue(4'h1, 1'b0, 4'd2, 4'd7, 4'd2, 16'($urandom), 0, 1);

      rand_phase(60);

      // reset while W is high
      issue(4'h6, 1'b1, 4'd9, 4'd0, 4'd0, 16'($urandom), 0, 0);
      d = 16'($urandom);
      wb_valid = 1'b1;
      wb_dst   = 4'd9;
      wb_data  = d;
      cyc();
      wb_valid = 1'b0;
      cyc();
      chk("rst_pre_w", 32'(w), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_w",      32'(w), 0);
      chk("arst_wsel",   32'(wsel), 0);
      chk("arst_din",    32'(din), 0);
      chk("arst_in_rdy", 32'(in_ready), 1);
      chk("arst_wb_rdy", 32'(wb_ready), 1);
      chk("arst_vld",    32'(out_valid), 0);
      chk("arst_a",      32'(out_a), 0);
      shadow[9] = d;
      mpend     = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rel_in_rdy", 32'(in_ready), 1);
      chk("rel_wb_rdy", 32'(wb_ready), 1);
      issue(4'h3, 1'b0, 4'd0, 4'd9, 4'd9, 16'($urandom), 0, 0);
      chk("post_rst_a", 32'(out_a), 32'(d));

      rand_phase(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
